// File: rtl/sha256_message_schedule.sv
// sha256_message_schedule: expands one 512-bit block into the 64-word SHA-256 schedule and serves it through a read port
module sha256_message_schedule #(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS = 64,
  localparam int IDX_W = $clog2(ROUNDS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [16*WORD_SIZE-1:0] block_in,
  input  logic                    block_valid,
  output logic                    block_ready,
  input  logic [IDX_W-1:0]        message_schedule_index,
  output logic [WORD_SIZE-1:0]    message_schedule_value,
  output logic                    schedule_ready,
  input  logic                    schedule_release,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] t_cnt;
  logic [WORD_SIZE-1:0] w [ROUNDS];
  logic [WORD_SIZE-1:0] s0_in, s1_in, s0, s1, w_new;
  logic accept;
  assign s1_in = w[t_cnt - IDX_W'(2)];
  assign s0_in = w[t_cnt - IDX_W'(15)];
  assign s0 = {s0_in[6:0], s0_in[31:7]} ^ {s0_in[17:0], s0_in[31:18]} ^ (s0_in >> 3);
  assign s1 = {s1_in[16:0], s1_in[31:17]} ^ {s1_in[18:0], s1_in[31:19]} ^ (s1_in >> 10);
  assign w_new = s1 + w[t_cnt - IDX_W'(7)] + s0 + w[t_cnt - IDX_W'(16)];
  assign accept = state == IDLE && block_valid && !clear;
  always_comb begin
    state_nxt = clear ? IDLE :
                state == IDLE   ? (block_valid ? EXPAND : IDLE) :
                state == EXPAND ? (t_cnt == IDX_W'(ROUNDS - 1) ? READY : EXPAND) :
                (schedule_release ? IDLE : READY);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      t_cnt <= IDX_W'(16);
      for (int i = 0; i < ROUNDS; i++) w[i] <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        t_cnt <= IDX_W'(16);
      end else if (accept) begin
        for (int i = 0; i < 16; i++) w[i] <= block_in[(15-i)*WORD_SIZE +: WORD_SIZE];
        t_cnt <= IDX_W'(16);
      end else if (state == EXPAND) begin
        w[t_cnt] <= w_new;
        t_cnt <= t_cnt + IDX_W'(1);
      end
    end
  end
  assign block_ready = state == IDLE;
  assign busy = state == EXPAND;
  assign schedule_ready = state == READY;
  assign message_schedule_value = w[message_schedule_index];
endmodule
